// File: rtl/general_pack.sv
`default_nettype none
// ============================================================================
// Package     : general_pack
// Description : Shared types and width helpers for the Avalon-ST length
//               limiter (state enum, beat counter / empty field widths).
// Revision    : 1.0 - initial release
// ============================================================================
package general_pack;

  // Limiter states: idle between messages, forwarding, discarding a tail
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IN_MSG = 2'd1,
    ST_DROP   = 2'd2
  } len_lim_sm_t;

  // Beat counter must hold the value MAX_MSG_BEATS itself
  function automatic int beat_cnt_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

  // Width of the Avalon-ST empty field for a given beat width in bytes
  function automatic int empty_width(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/avalon_st_if.sv
`default_nettype none
// ============================================================================
// Interface   : avalon_st_if
// Description : Avalon-ST beat bundle with sop/eop/empty framing and a
//               ready/valid handshake (rdy driven by the sink).
// Revision    : 1.0 - initial release
// ============================================================================
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
  logic                             valid;
  logic                             rdy;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_W-1:0]               empty;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface
`default_nettype wire

// File: rtl/avalon_st_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : avalon_st_pipe_reg
// Description : Single-entry Avalon-ST output register. Loads a new beat
//               whenever it is empty or its current beat is being taken;
//               otherwise holds every field stable.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_st_pipe_reg #(
  parameter int DATA_W  = 128,
  parameter int EMPTY_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic               sop_i,
  input  logic               eop_i,
  input  logic [EMPTY_W-1:0] empty_i,
  output logic               space_o,
  output logic               valid_o,
  output logic [DATA_W-1:0]  data_o,
  output logic               sop_o,
  output logic               eop_o,
  output logic [EMPTY_W-1:0] empty_o,
  input  logic               rdy_i
);

  logic               valid_q;
  logic [DATA_W-1:0]  data_q;
  logic               sop_q;
  logic               eop_q;
  logic [EMPTY_W-1:0] empty_q;

  // Room for a new beat when empty or when the held beat leaves this cycle
  assign space_o = ~valid_q | rdy_i;

  // Output register: update only when the slot is free, else hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= '0;
    end else if (space_o) begin
      valid_q <= load_i;
      if (load_i) begin
        data_q  <= data_i;
        sop_q   <= sop_i;
        eop_q   <= eop_i;
        empty_q <= empty_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;
  assign empty_o = empty_q;

endmodule
`default_nettype wire

// File: rtl/avalon_len_limiter.sv
`default_nettype none
// ============================================================================
// Module      : avalon_len_limiter
// Description : Truncates Avalon-ST messages longer than MAX_MSG_BEATS.
//               The beat numbered MAX_MSG_BEATS is forced to eop (empty=0),
//               too_long pulses, and the rest of the message is dropped.
//               Optional statistics counters: define
//               AVALON_LEN_LIMITER_STATS_EN to enable msg_count/trunc_count.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_len_limiter
  import general_pack::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int MAX_MSG_BEATS       = 64
) (
  input  logic        clk,
  input  logic        rst,
  avalon_st_if.slave  in_msg,
  avalon_st_if.master out_msg,
  output logic        too_long,
  output logic [31:0] msg_count,
  output logic [15:0] trunc_count
);

  localparam int DATA_W  = DATA_WIDTH_IN_BYTES * 8;
  localparam int EMPTY_W = empty_width(DATA_WIDTH_IN_BYTES);
  localparam int CNT_W   = beat_cnt_width(MAX_MSG_BEATS);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MSG_BEATS);

  len_lim_sm_t        state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               too_long_q;
  logic               w_pipe_space;
  logic               w_in_rdy;
  logic               w_acc;
  logic               w_fwd;
  logic               w_eop_out;
  logic               w_trunc;
  logic [EMPTY_W-1:0] w_empty_out;

  // Dropped tails are swallowed at full rate. The only exception is an sop
  // beat arriving while the output register is stalled: it has to be
  // forwarded, so it waits instead of being accepted and lost.
  assign w_in_rdy   = (state_q == ST_DROP) ? ~(in_msg.sop & ~w_pipe_space) : w_pipe_space;
  assign in_msg.rdy = w_in_rdy;
  assign w_acc      = in_msg.valid & w_in_rdy;
  // Only evaluated in IN_MSG where beat_cnt_q < MAX_MSG_BEATS, so never wraps
  assign w_cnt_inc  = beat_cnt_q + 1'b1;

  // Next-state, forward and truncate decisions for the accepted beat
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    w_fwd      = 1'b0;
    w_trunc    = 1'b0;
    w_eop_out  = in_msg.eop;
    case (state_q)
      ST_IDLE, ST_DROP: begin
        if (w_acc && in_msg.sop) begin
          w_fwd      = 1'b1;
          beat_cnt_d = CNT_W'(1);
          state_d    = in_msg.eop ? ST_IDLE : ST_IN_MSG;
        end else if (w_acc && in_msg.eop && (state_q == ST_DROP)) begin
          state_d = ST_IDLE;
        end
      end
      ST_IN_MSG: begin
        if (w_acc) begin
          w_fwd = 1'b1;
          if (in_msg.sop) begin
            beat_cnt_d = CNT_W'(1);
            state_d    = in_msg.eop ? ST_IDLE : ST_IN_MSG;
          end else begin
            beat_cnt_d = w_cnt_inc;
            if (in_msg.eop) begin
              state_d = ST_IDLE;
            end else if (w_cnt_inc == MAX_CNT) begin
              w_trunc   = 1'b1;
              w_eop_out = 1'b1;
              state_d   = ST_DROP;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Truncated beats carry a full last beat; natural eop keeps upstream empty
  assign w_empty_out = (w_eop_out && !w_trunc) ? in_msg.empty : '0;

  // State, beat counter and too_long pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      too_long_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      too_long_q <= w_trunc;
    end
  end

  assign too_long = too_long_q;

  avalon_st_pipe_reg #(
    .DATA_W  (DATA_W),
    .EMPTY_W (EMPTY_W)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (w_fwd),
    .data_i  (in_msg.data),
    .sop_i   (in_msg.sop),
    .eop_i   (w_eop_out),
    .empty_i (w_empty_out),
    .space_o (w_pipe_space),
    .valid_o (out_msg.valid),
    .data_o  (out_msg.data),
    .sop_o   (out_msg.sop),
    .eop_o   (out_msg.eop),
    .empty_o (out_msg.empty),
    .rdy_i   (out_msg.rdy)
  );

`ifdef AVALON_LEN_LIMITER_STATS_EN
  logic [31:0] msg_cnt_q;
  logic [15:0] trunc_cnt_q;

  // Saturating counters: completed output messages and truncations
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_cnt_q   <= '0;
      trunc_cnt_q <= '0;
    end else begin
      if (out_msg.valid && out_msg.rdy && out_msg.eop && !(&msg_cnt_q)) begin
        msg_cnt_q <= msg_cnt_q + 32'd1;
      end
      if (w_trunc && !(&trunc_cnt_q)) begin
        trunc_cnt_q <= trunc_cnt_q + 16'd1;
      end
    end
  end

  assign msg_count   = msg_cnt_q;
  assign trunc_count = trunc_cnt_q;
`else
  assign msg_count   = 32'd0;
  assign trunc_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_avalon_len_limiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_len_limiter
// Description : Directed self-checking bench for avalon_len_limiter with
//               MAX_MSG_BEATS=4 and 16-byte beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_len_limiter;

`ifdef AVALON_LEN_LIMITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [127:0] data;
    logic         sop;
    logic         eop;
    logic [3:0]   empty;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        too_long;
  logic [31:0] msg_count;
  logic [15:0] trunc_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int tl_pulses    = 0;
  beat_t q[$];

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) in_if ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) out_if ();

  avalon_len_limiter #(
    .DATA_WIDTH_IN_BYTES (16),
    .MAX_MSG_BEATS       (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_msg      (in_if.slave),
    .out_msg     (out_if.master),
    .too_long    (too_long),
    .msg_count   (msg_count),
    .trunc_count (trunc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect every output handshake and too_long pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst && out_if.valid && out_if.rdy) begin
      q.push_back({out_if.data, out_if.sop, out_if.eop, out_if.empty});
    end
    if (too_long) tl_pulses++;
  end

  function automatic beat_t mk(input logic [7:0] tag, input logic s, input logic e,
                               input logic [3:0] emp);
    mk = {120'd0, tag, s, e, emp};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_in();
    in_if.valid = 1'b0;
    in_if.sop   = 1'b0;
    in_if.eop   = 1'b0;
  endtask

  // Present one beat until accepted; ft=1 if accepted on its first cycle
  task automatic drive_beat(input logic [7:0] tag, input logic s, input logic e,
                            input logic [3:0] emp, output bit ft);
    bit acc;
    int n;
    acc = 1'b0;
    ft  = 1'b0;
    n   = 0;
    in_if.valid = 1'b1;
    in_if.data  = {120'd0, tag};
    in_if.sop   = s;
    in_if.eop   = e;
    in_if.empty = emp;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_if.rdy;
      if (acc && n == 0) ft = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drive_beat_timeout tag=%h accepted=0 required=1", tag);
    end
  endtask

  task automatic test_reset();
    #3;
    tests_run++;
    if ({out_if.valid, out_if.sop, out_if.eop} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ctrl got=%b exp=000", {out_if.valid, out_if.sop, out_if.eop});
    end
    tests_run++;
    if ({out_if.data, out_if.empty} !== 132'd0) begin
      tests_failed++;
      $display("FAIL reset_data got=%h exp=0", {out_if.data, out_if.empty});
    end
    tests_run++;
    if ({too_long, msg_count, trunc_count} !== 49'd0) begin
      tests_failed++;
      $display("FAIL reset_stats got=%h exp=0", {too_long, msg_count, trunc_count});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_pass();
    bit ft;
    beat_t exp [3];
    exp[0] = mk(8'h11, 1'b1, 1'b0, 4'd0);
    exp[1] = mk(8'h12, 1'b0, 1'b0, 4'd0);
    exp[2] = mk(8'h13, 1'b0, 1'b1, 4'd2);
    q.delete();
    tl_pulses = 0;
    drive_beat(8'h11, 1'b1, 1'b0, 4'd0, ft);
    tests_run++;
    if ({out_if.valid, out_if.sop, out_if.data[7:0]} !== {1'b1, 1'b1, 8'h11}) begin
      tests_failed++;
      $display("FAIL pass_latency got=%b/%b/%h exp=1/1/11", out_if.valid, out_if.sop, out_if.data[7:0]);
    end
    drive_beat(8'h12, 1'b0, 1'b0, 4'd0, ft);
    drive_beat(8'h13, 1'b0, 1'b1, 4'd2, ft);
    idle_in();
    wait_cycles(3);
    tests_run++;
    if (q.size() !== 3) begin
      tests_failed++;
      $display("FAIL pass_count got=%0d exp=3", q.size());
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (i >= q.size() || q[i] !== exp[i]) begin
        tests_failed++;
        $display("FAIL pass_beat%0d got=%h exp=%h", i, (i < q.size()) ? q[i] : '0, exp[i]);
      end
    end
    tests_run++;
    if (tl_pulses !== 0 || msg_count !== (STATS ? 32'd1 : 32'd0)) begin
      tests_failed++;
      $display("FAIL pass_stats got tl=%0d msg=%0d exp tl=0 msg=%0d", tl_pulses, msg_count, STATS ? 1 : 0);
    end
  endtask

  task automatic test_truncate();
    bit ft;
    beat_t exp [4];
    exp[0] = mk(8'h21, 1'b1, 1'b0, 4'd0);
    exp[1] = mk(8'h22, 1'b0, 1'b0, 4'd0);
    exp[2] = mk(8'h23, 1'b0, 1'b0, 4'd0);
    exp[3] = mk(8'h24, 1'b0, 1'b1, 4'd0);
    q.delete();
    tl_pulses = 0;
    drive_beat(8'h21, 1'b1, 1'b0, 4'd0, ft);
    drive_beat(8'h22, 1'b0, 1'b0, 4'd0, ft);
    drive_beat(8'h23, 1'b0, 1'b0, 4'd0, ft);
    drive_beat(8'h24, 1'b0, 1'b0, 4'd0, ft);
    for (int b = 5; b <= 7; b++) begin
      drive_beat(8'h20 + 8'(b), 1'b0, (b == 7), 4'd3, ft);
      tests_run++;
      if (ft !== 1'b1) begin
        tests_failed++;
        $display("FAIL trunc_drop_rdy beat%0d got=%b exp=1", b, ft);
      end
    end
    idle_in();
    wait_cycles(3);
    tests_run++;
    if (q.size() !== 4) begin
      tests_failed++;
      $display("FAIL trunc_count got=%0d exp=4", q.size());
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= q.size() || q[i] !== exp[i]) begin
        tests_failed++;
        $display("FAIL trunc_beat%0d got=%h exp=%h", i, (i < q.size()) ? q[i] : '0, exp[i]);
      end
    end
    tests_run++;
    if (tl_pulses !== 1) begin
      tests_failed++;
      $display("FAIL trunc_pulse got=%0d exp=1", tl_pulses);
    end
    tests_run++;
    if (trunc_count !== (STATS ? 16'd1 : 16'd0) || msg_count !== (STATS ? 32'd2 : 32'd0)) begin
      tests_failed++;
      $display("FAIL trunc_stats got trunc=%0d msg=%0d exp trunc=%0d msg=%0d",
               trunc_count, msg_count, STATS ? 1 : 0, STATS ? 2 : 0);
    end
  endtask

  task automatic test_exact_max();
    bit ft;
    beat_t exp [4];
    exp[0] = mk(8'h31, 1'b1, 1'b0, 4'd0);
    exp[1] = mk(8'h32, 1'b0, 1'b0, 4'd0);
    exp[2] = mk(8'h33, 1'b0, 1'b0, 4'd0);
    exp[3] = mk(8'h34, 1'b0, 1'b1, 4'd5);
    q.delete();
    tl_pulses = 0;
    for (int b = 0; b < 4; b++) begin
      drive_beat(8'h31 + 8'(b), (b == 0), (b == 3), (b == 3) ? 4'd5 : 4'd0, ft);
    end
    idle_in();
    wait_cycles(3);
    tests_run++;
    if (q.size() !== 4) begin
      tests_failed++;
      $display("FAIL exact_count got=%0d exp=4", q.size());
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= q.size() || q[i] !== exp[i]) begin
        tests_failed++;
        $display("FAIL exact_beat%0d got=%h exp=%h", i, (i < q.size()) ? q[i] : '0, exp[i]);
      end
    end
    tests_run++;
    if (tl_pulses !== 0) begin
      tests_failed++;
      $display("FAIL exact_pulse got=%0d exp=0", tl_pulses);
    end
  endtask

  task automatic test_backpressure();
    bit ft;
    beat_t exp [4];
    exp[0] = mk(8'h41, 1'b1, 1'b0, 4'd0);
    exp[1] = mk(8'h42, 1'b0, 1'b0, 4'd0);
    exp[2] = mk(8'h43, 1'b0, 1'b0, 4'd0);
    exp[3] = mk(8'h44, 1'b0, 1'b1, 4'd1);
    q.delete();
    out_if.rdy = 1'b0;
    drive_beat(8'h41, 1'b1, 1'b0, 4'd0, ft);
    in_if.valid = 1'b1;
    in_if.data  = {120'd0, 8'h42};
    in_if.sop   = 1'b0;
    in_if.eop   = 1'b0;
    in_if.empty = 4'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if ({in_if.rdy, out_if.valid, out_if.sop, out_if.eop, out_if.data[7:0]} !==
          {1'b0, 1'b1, 1'b1, 1'b0, 8'h41}) begin
        tests_failed++;
        $display("FAIL stall_cycle%0d got rdy=%b v=%b sop=%b eop=%b d=%h exp rdy=0 v=1 sop=1 eop=0 d=41",
                 c, in_if.rdy, out_if.valid, out_if.sop, out_if.eop, out_if.data[7:0]);
      end
    end
    @(posedge clk);
    #1;
    out_if.rdy = 1'b1;
    drive_beat(8'h42, 1'b0, 1'b0, 4'd0, ft);
    drive_beat(8'h43, 1'b0, 1'b0, 4'd0, ft);
    drive_beat(8'h44, 1'b0, 1'b1, 4'd1, ft);
    idle_in();
    wait_cycles(3);
    tests_run++;
    if (q.size() !== 4) begin
      tests_failed++;
      $display("FAIL stall_count got=%0d exp=4", q.size());
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= q.size() || q[i] !== exp[i]) begin
        tests_failed++;
        $display("FAIL stall_beat%0d got=%h exp=%h", i, (i < q.size()) ? q[i] : '0, exp[i]);
      end
    end
  endtask

  task automatic test_drop_sop();
    bit ft;
    beat_t exp [8];
    exp[0] = mk(8'h51, 1'b1, 1'b0, 4'd0);
    exp[1] = mk(8'h52, 1'b0, 1'b0, 4'd0);
    exp[2] = mk(8'h53, 1'b0, 1'b0, 4'd0);
    exp[3] = mk(8'h54, 1'b0, 1'b1, 4'd0);
    exp[4] = mk(8'h60, 1'b1, 1'b0, 4'd0);
    exp[5] = mk(8'h61, 1'b0, 1'b0, 4'd0);
    exp[6] = mk(8'h62, 1'b0, 1'b0, 4'd0);
    exp[7] = mk(8'h63, 1'b0, 1'b1, 4'd0);
    q.delete();
    tl_pulses = 0;
    for (int b = 0; b < 5; b++) begin
      drive_beat(8'h51 + 8'(b), (b == 0), 1'b0, 4'd0, ft);
    end
    drive_beat(8'h60, 1'b1, 1'b0, 4'd0, ft);
    for (int b = 1; b < 5; b++) begin
      drive_beat(8'h60 + 8'(b), 1'b0, (b == 4), 4'd2, ft);
    end
    idle_in();
    wait_cycles(3);
    tests_run++;
    if (q.size() !== 8) begin
      tests_failed++;
      $display("FAIL dropsop_count got=%0d exp=8", q.size());
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (i >= q.size() || q[i] !== exp[i]) begin
        tests_failed++;
        $display("FAIL dropsop_beat%0d got=%h exp=%h", i, (i < q.size()) ? q[i] : '0, exp[i]);
      end
    end
    tests_run++;
    if (tl_pulses !== 2) begin
      tests_failed++;
      $display("FAIL dropsop_pulses got=%0d exp=2", tl_pulses);
    end
  endtask

  task automatic test_reset_mid();
    bit ft;
    q.delete();
    drive_beat(8'h71, 1'b1, 1'b0, 4'd0, ft);
    in_if.valid = 1'b1;
    in_if.data  = {120'd0, 8'h72};
    in_if.sop   = 1'b0;
    in_if.eop   = 1'b0;
    #2;
    rst = 1'b1;
    idle_in();
    #1;
    tests_run++;
    if ({out_if.valid, out_if.sop, out_if.eop, too_long} !== 4'b0000 ||
        {out_if.data, out_if.empty} !== 132'd0 || msg_count !== 32'd0 || trunc_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs got v=%b sop=%b eop=%b tl=%b d=%h msg=%0d trunc=%0d exp all 0",
               out_if.valid, out_if.sop, out_if.eop, too_long, out_if.data, msg_count, trunc_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    drive_beat(8'h73, 1'b0, 1'b0, 4'd0, ft);
    drive_beat(8'h74, 1'b0, 1'b1, 4'd2, ft);
    idle_in();
    wait_cycles(3);
    tests_run++;
    if (q.size() !== 0) begin
      tests_failed++;
      $display("FAIL rstmid_discard got=%0d exp=0", q.size());
    end
    drive_beat(8'h7A, 1'b1, 1'b1, 4'd7, ft);
    idle_in();
    wait_cycles(3);
    tests_run++;
    if (q.size() !== 1 || q[0] !== mk(8'h7A, 1'b1, 1'b1, 4'd7)) begin
      tests_failed++;
      $display("FAIL rstmid_next got n=%0d b=%h exp n=1 b=%h", q.size(),
               (q.size() > 0) ? q[0] : '0, mk(8'h7A, 1'b1, 1'b1, 4'd7));
    end
  endtask

  initial begin
    rst          = 1'b1;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    in_if.sop    = 1'b0;
    in_if.eop    = 1'b0;
    in_if.empty  = '0;
    out_if.rdy   = 1'b1;
    test_reset();
    test_pass();
    test_truncate();
    test_exact_max();
    test_backpressure();
    test_drop_sop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
